// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control definitions: sequencer state encoding and drain length,
// also used by the debug unit to decode o_state.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } seq_state_t;

  localparam int unsigned DRAIN_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer for the five-stage pipeline: merges load-use stalls and
// branch flushes into register write enables and keeps cycle/stall counters.
module pipeline_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_run,
  input  logic                 i_step,
  input  logic                 i_stop,
  input  logic                 i_halt_detected,
  input  logic                 i_hazard_stall,
  input  logic                 i_branch_taken,
  output logic                 o_pc_write,
  output logic                 o_if_id_write,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_bubble,
  output logic                 o_back_enable,
  output logic                 o_halted,
  output logic                 o_busy,
  output logic [2:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_cycle_count,
  output logic [CNT_WIDTH-1:0] o_stall_count
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

  seq_state_t    state, state_next;
  logic [DW-1:0] drain_cnt;
  logic          drain_last;
  logic          enabled;
  logic          stall_applied;

  assign drain_last = (drain_cnt == DW'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == ST_DRAIN && !drain_last) ? drain_cnt + DW'(1) : '0;
    end
  end

  always_comb begin
    state_next     = state;
    enabled        = 1'b0;
    stall_applied  = 1'b0;
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_back_enable  = 1'b0;
    o_halted       = 1'b0;
    o_busy         = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (i_run)       state_next = ST_RUN;
        else if (i_step) state_next = ST_STEP;
      end
      ST_RUN: begin
        enabled = 1'b1;
        if (i_halt_detected)       state_next = ST_DRAIN;
        else if (i_stop || !i_run) state_next = ST_IDLE;
      end
      ST_STEP: begin
        enabled    = 1'b1;
        state_next = i_halt_detected ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        o_busy        = 1'b1;
        o_if_id_flush = 1'b1;
        o_back_enable = 1'b1;
        if (drain_last) state_next = ST_HALTED;
      end
      ST_HALTED: o_halted = 1'b1;
      default:   state_next = ST_IDLE;
    endcase

    // A stalled branch is still sitting in ID and re-resolves next cycle, so the
    // stall masks the flush rather than the other way round.
    if (enabled) begin
      o_busy         = 1'b1;
      o_back_enable  = 1'b1;
      stall_applied  = i_hazard_stall;
      o_pc_write     = !i_hazard_stall;
      o_if_id_write  = !i_hazard_stall;
      o_id_ex_bubble = i_hazard_stall;
      o_if_id_flush  = i_branch_taken && !i_hazard_stall;
    end
  end

  assign o_state = state;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
    .clk    (clk),
    .clear  (rst),
    .enable (o_back_enable),
    .count  (o_cycle_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk    (clk),
    .clear  (rst),
    .enable (stall_applied),
    .count  (o_stall_count)
  );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomised and directed check of pipeline_sequencer against a mode-level model;
// a 4-bit-counter copy shares the stimulus to exercise counter saturation.
module tb_pipeline_sequencer;

  localparam int unsigned DRAIN = 4;

  logic clk = 1'b0;
  logic rst, run, step, stop, halt, hz, br;

  logic        pc_w, ifid_w, flush, bubble, back, halted, busy;
  logic [2:0]  state;
  logic [31:0] cyc, stl;
  logic        s_pc_w, s_ifid_w, s_flush, s_bubble, s_back, s_halted, s_busy;
  logic [2:0]  s_state;
  logic [3:0]  s_cyc, s_stl;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // model: mode 0=idle 1=run 2=step 3=drain 4=halted
  int          m_mode;
  int          m_left;
  longint      m_cyc, m_stall;

  always #5 clk = ~clk;

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_run(run), .i_step(step), .i_stop(stop),
    .i_halt_detected(halt), .i_hazard_stall(hz), .i_branch_taken(br),
    .o_pc_write(pc_w), .o_if_id_write(ifid_w), .o_if_id_flush(flush),
    .o_id_ex_bubble(bubble), .o_back_enable(back), .o_halted(halted),
    .o_busy(busy), .o_state(state), .o_cycle_count(cyc), .o_stall_count(stl)
  );

  pipeline_sequencer #(.DRAIN_CYCLES(DRAIN), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .i_run(run), .i_step(step), .i_stop(stop),
    .i_halt_detected(halt), .i_hazard_stall(hz), .i_branch_taken(br),
    .o_pc_write(s_pc_w), .o_if_id_write(s_ifid_w), .o_if_id_flush(s_flush),
    .o_id_ex_bubble(s_bubble), .o_back_enable(s_back), .o_halted(s_halted),
    .o_busy(s_busy), .o_state(s_state), .o_cycle_count(s_cyc), .o_stall_count(s_stl)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint max);
    return (v > max) ? max : v;
  endfunction

  task automatic check_outputs();
    bit en, drn;
    logic [6:0] exp_ctl;
    en  = (m_mode == 1) || (m_mode == 2);
    drn = (m_mode == 3);
    // {pc_write, if_id_write, flush, bubble, back_enable, halted, busy}
    exp_ctl = {en && !hz, en && !hz, drn || (en && br && !hz), en && hz,
               en || drn, m_mode == 4, en || drn};
    check("ctl",        {pc_w, ifid_w, flush, bubble, back, halted, busy}, exp_ctl);
    check("ctl_small",  {s_pc_w, s_ifid_w, s_flush, s_bubble, s_back, s_halted, s_busy}, exp_ctl);
    check("state",      state, m_mode);
    check("cycle_cnt",  cyc, sat(m_cyc, 64'hFFFF_FFFF));
    check("stall_cnt",  stl, sat(m_stall, 64'hFFFF_FFFF));
    check("cycle_sat4", s_cyc, sat(m_cyc, 15));
    check("stall_sat4", s_stl, sat(m_stall, 15));
  endtask

  task automatic model_update();
    bit en;
    en = (m_mode == 1) || (m_mode == 2);
    if (rst) begin
      m_mode = 0; m_left = 0; m_cyc = 0; m_stall = 0;
      return;
    end
    if (en || m_mode == 3) m_cyc++;
    if (en && hz)          m_stall++;
    case (m_mode)
      0: if (run) m_mode = 1; else if (step) m_mode = 2;
      1: if (halt) begin m_mode = 3; m_left = DRAIN; end
         else if (stop || !run) m_mode = 0;
      2: if (halt) begin m_mode = 3; m_left = DRAIN; end
         else m_mode = 0;
      3: begin m_left--; if (m_left == 0) m_mode = 4; end
      default: ;
    endcase
  endtask

  // Inputs are already set (at negedge); check, clock, advance the model.
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic s, input logic sp, input logic h,
                       input logic z, input logic b, input logic rs);
    run = r; step = s; stop = sp; halt = h; hz = z; br = b; rst = rs;
    tick();
  endtask

  initial begin
    {run, step, stop, halt, hz, br} = '0;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    m_mode = 0; m_left = 0; m_cyc = 0; m_stall = 0;
    rst = 1'b0;

    // single step
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);

    // free run with a stall in the fifth run cycle
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) drive(1, 0, 0, 0, i == 5, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // branch+stall together, then branch alone
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // stop pulse with run held, then resume
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0);

    // halt with a simultaneous stall, drain, then commands ignored while halted
    drive(1, 0, 0, 1, 1, 0, 0);
    repeat (6) drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);

    // reset during the second drain cycle
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // long run drives the 4-bit copy into saturation
    repeat (25) drive(1, 0, 0, 0, ($urandom_range(0, 3) == 0), 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) != 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 12) == 0,
            $urandom_range(0, 40) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 80) == 0 || (m_mode == 4 && $urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central run/stall/flush controller for the five-stage MIPS pipeline.
- Sequences the pipeline through idle, free-run, single-step, halt-drain and halted modes under debug-unit command.
- Merges the hazard detector's load-use stall request and the ID-stage branch-taken flush into per-register write enables, flush and bubble controls.
- Keeps cycle and stall counters for the debug unit to read out.

Parameters:
- DRAIN_CYCLES, 4: cycles the back end (ID/EX, EX/MEM, MEM/WB) keeps running after HALT reaches ID, so HALT retires from WB.
- CNT_WIDTH, 32: width of the cycle and stall counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_run  in  1  level; start or continue free-run.
- i_step  in  1  one-cycle pulse; advance the pipeline exactly one clock.
- i_stop  in  1  one-cycle pulse; pause free-run.
- i_halt_detected  in  1  HALT opcode decoded in ID.
- i_hazard_stall  in  1  load-use stall request from the hazard detector (inverse of its PCWrite).
- i_branch_taken  in  1  branch/jump resolved taken in ID.
- o_pc_write  out  1  PC register write enable.
- o_if_id_write  out  1  IF/ID register write enable.
- o_if_id_flush  out  1  clear IF/ID to NOP.
- o_id_ex_bubble  out  1  zero control bits into ID/EX.
- o_back_enable  out  1  write enable for ID/EX, EX/MEM, MEM/WB and register file/data memory writes.
- o_halted  out  1  pipeline halted and drained.
- o_busy  out  1  state is RUN, STEP or DRAIN.
- o_state  out  3  current state encoding, for debug readout.
- o_cycle_count  out  CNT_WIDTH  cycles with o_back_enable=1.
- o_stall_count  out  CNT_WIDTH  cycles with a hazard stall applied.

Behaviour:
- Reset: state IDLE, both counters 0, drain counter 0. All outputs 0 except o_state=IDLE.
- Timing: state register is synchronous. Outputs are combinational from state and current-cycle inputs. A command sampled in cycle n takes effect in cycle n+1.
- States (3-bit encoding in the package): IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- IDLE: all enables 0.
  - i_run -> RUN.
  - else i_step -> STEP.
  - i_stop is ignored.
- RUN: pipeline enabled.
  - i_halt_detected -> DRAIN (has priority).
  - else i_stop or !i_run -> IDLE.
  - i_step is ignored.
- STEP: pipeline enabled for exactly one cycle.
  - i_halt_detected -> DRAIN.
  - else -> IDLE.
- DRAIN: o_pc_write=0, o_if_id_write=0, o_if_id_flush=1, o_back_enable=1.
  - Drain counter counts DRAIN_CYCLES cycles, then -> HALTED.
  - i_run, i_step and i_stop are ignored.
- HALTED: all enables 0, o_halted=1. Sticky until rst.
- Enabled cycle (RUN/STEP) defaults: o_pc_write=1, o_if_id_write=1, o_back_enable=1, flush=0, bubble=0.
- Enabled cycle with i_hazard_stall: o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1.
- Enabled cycle with i_branch_taken: o_if_id_flush=1, o_pc_write=1.
- Simultaneous stall and branch_taken: stall wins, flush suppressed. The branch is the stalled instruction and resolves again next cycle.
- Simultaneous halt and stall: the stall is applied that cycle, then DRAIN.
- Hazard and branch inputs are ignored outside RUN/STEP.
- Counters:
  - o_cycle_count increments when o_back_enable=1.
  - o_stall_count increments on each applied stall.
  - Both saturate at all-ones and never wrap.
- rst mid-operation (including mid-DRAIN) returns to IDLE with counters cleared on the next edge.

Decomposition:
- Shared package pipeline_ctrl_pkg: state encoding constants (3 bits) and the DRAIN_CYCLES default. The debug unit reuses both.
- One sub-module is natural: sat_counter (enable, synchronous clear, saturating, parameter WIDTH), instantiated twice for the cycle and stall counters.
- FSM and output decode stay in pipeline_sequencer.

Test Plan:
- Reset, then i_step pulse -> exactly one cycle with o_back_enable=1 and o_pc_write=1, then IDLE; o_cycle_count=1.
- i_run held 10 cycles, i_hazard_stall high in cycle 5 -> that cycle pc_write=0, if_id_write=0, bubble=1; o_stall_count=1, o_cycle_count=10.
- RUN with i_branch_taken and i_hazard_stall together, then i_branch_taken alone next cycle -> first cycle flush=0 and stall applied; second cycle flush=1, pc_write=1.
- RUN, i_halt_detected pulse -> 4 DRAIN cycles with pc_write=0, back_enable=1; then o_halted=1 and o_busy=0; later i_run is ignored.
- RUN, i_stop pulse with i_run still high -> IDLE next cycle; counters hold; i_run re-asserted resumes RUN.
- rst asserted on the 2nd DRAIN cycle -> IDLE, counters 0, o_halted=0 next cycle; preload counter near all-ones -> saturates and does not wrap.
